// File: rtl/filter_slice_packer.sv
// -----------------------------------------------------------------------------
// filter_slice_packer
//
// Write side of the packed filter-output RAM. Band-pass filter samples arrive
// as an Avalon-ST stream, one SLICE_W-bit sample per valid beat, with no
// backpressure. Every three accepted samples are packed into one 3*SLICE_W
// word and written to the RAM. The layout matches the downstream slice reader:
//   slice1 -> [SLICE_W-1:0], slice2 -> [2*SLICE_W-1:SLICE_W],
//   slice3 -> [3*SLICE_W-1:2*SLICE_W]
//
// Optional feature (compile-time macro PACKER_ERR_DROP_EN):
//   defined   : valid beats with a nonzero error code are not packed and do not
//               advance the slice counter; they still set err_seen.
//   undefined : errored beats are packed like good beats; only err_seen
//               records them.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   one-cycle pulse, arms or re-arms a frame
//   flush          in   one-cycle pulse, writes any partial word, ends frame
//   ast_sink_data  in   filter sample (SLICE_W)
//   ast_sink_valid in   sample valid
//   ast_sink_error in   filter error code, nonzero marks a bad sample
//   ram_addr       out  RAM write address (ADDR_W)
//   ram_data       out  packed RAM word (3*SLICE_W)
//   ram_wren       out  write strobe, one cycle per word
//   words_written  out  words written this frame, saturates at NUM_WORDS
//   busy           out  high in PACK and FLUSH
//   done           out  high in DONE
//   err_seen       out  sticky, a nonzero error code was accepted
//   overflow       out  sticky, a valid sample arrived while in DONE
// -----------------------------------------------------------------------------
module filter_slice_packer #(
    parameter int SLICE_W   = 31,
    parameter int ADDR_W    = 11,
    parameter int NUM_WORDS = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   flush,
    input  logic [SLICE_W-1:0]     ast_sink_data,
    input  logic                   ast_sink_valid,
    input  logic [1:0]             ast_sink_error,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [3*SLICE_W-1:0]   ram_data,
    output logic                   ram_wren,
    output logic [ADDR_W:0]        words_written,
    output logic                   busy,
    output logic                   done,
    output logic                   err_seen,
    output logic                   overflow
);

    localparam int WORD_W = 3 * SLICE_W;
    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          slice_cnt_q, slice_cnt_d;
    logic [WORD_W-1:0]   stage_q, stage_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                err_seen_q, err_seen_d;
    logic                overflow_q, overflow_d;

    logic                beat_err;
    logic                accept;
    logic                frame_end;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] cnt);
        return (cnt < MAX_WORDS) ? cnt + 1'b1 : cnt;
    endfunction

    assign beat_err = ast_sink_valid && (ast_sink_error != 2'b00);

`ifdef PACKER_ERR_DROP_EN
    assign accept = ast_sink_valid && (ast_sink_error == 2'b00);
`else
    assign accept = ast_sink_valid;
`endif

    always_comb begin
        state_d     = state_q;
        slice_cnt_d = slice_cnt_q;
        stage_d     = stage_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wren_d  = 1'b0;
        words_d     = words_q;
        err_seen_d  = err_seen_q;
        overflow_d  = overflow_q;
        frame_end   = 1'b0;

        if (start) begin
            // start wins over everything in every state: fresh frame, any
            // partial staging is dropped without a write.
            state_d     = S_PACK;
            slice_cnt_d = 2'd0;
            stage_d     = '0;
            ram_addr_d  = '0;
            ram_data_d  = '0;
            words_d     = '0;
            err_seen_d  = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                S_PACK: begin
                    if (beat_err) begin
                        err_seen_d = 1'b1;
                    end
                    if (accept) begin
                        case (slice_cnt_q)
                            2'd0: begin
                                stage_d[SLICE_W-1:0] = ast_sink_data;
                                slice_cnt_d          = 2'd1;
                            end
                            2'd1: begin
                                stage_d[2*SLICE_W-1:SLICE_W] = ast_sink_data;
                                slice_cnt_d                  = 2'd2;
                            end
                            default: begin
                                // Third slice goes straight to the output
                                // register; staging is freed so the next
                                // beat lands in slice1 without a bubble.
                                ram_data_d  = {ast_sink_data, stage_q[2*SLICE_W-1:0]};
                                ram_addr_d  = words_q[ADDR_W-1:0];
                                ram_wren_d  = 1'b1;
                                words_d     = sat_inc(words_q);
                                slice_cnt_d = 2'd0;
                                stage_d     = '0;
                                if (words_q == LAST_WORD) begin
                                    state_d   = S_DONE;
                                    frame_end = 1'b1;
                                end
                            end
                        endcase
                    end
                    // flush sees the slice count after this cycle's sample
                    if (flush && !frame_end) begin
                        state_d = (slice_cnt_d != 2'd0) ? S_FLUSH : S_DONE;
                    end
                end

                S_FLUSH: begin
                    // Unused slices are already zero: staging is cleared on
                    // every word boundary and restart.
                    ram_data_d  = stage_q;
                    ram_addr_d  = words_q[ADDR_W-1:0];
                    ram_wren_d  = 1'b1;
                    words_d     = sat_inc(words_q);
                    slice_cnt_d = 2'd0;
                    stage_d     = '0;
                    state_d     = S_DONE;
                end

                S_DONE: begin
                    if (ast_sink_valid) begin
                        overflow_d = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            slice_cnt_q <= 2'd0;
            stage_q     <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_wren_q  <= 1'b0;
            words_q     <= '0;
            err_seen_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_cnt_q <= slice_cnt_d;
            stage_q     <= stage_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_wren_q  <= ram_wren_d;
            words_q     <= words_d;
            err_seen_q  <= err_seen_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign ram_wren      = ram_wren_q;
    assign words_written = words_q;
    assign busy          = (state_q == S_PACK) || (state_q == S_FLUSH);
    assign done          = (state_q == S_DONE);
    assign err_seen      = err_seen_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_filter_slice_packer.sv
// -----------------------------------------------------------------------------
// tb_filter_slice_packer
//
// Self-checking bench for filter_slice_packer (NUM_WORDS reduced to 4 so the
// frame-end path is reachable). Expected RAM writes are pushed to a queue as
// stimulus is driven and popped by a monitor whenever ram_wren is seen.
// -----------------------------------------------------------------------------
module tb_filter_slice_packer;

    localparam int SW  = 31;
    localparam int AW  = 11;
    localparam int NW  = 4;
    localparam int WW  = 3 * SW;

    logic            clk;
    logic            rst;
    logic            start;
    logic            flush;
    logic [SW-1:0]   ast_sink_data;
    logic            ast_sink_valid;
    logic [1:0]      ast_sink_error;
    logic [AW-1:0]   ram_addr;
    logic [WW-1:0]   ram_data;
    logic            ram_wren;
    logic [AW:0]     words_written;
    logic            busy;
    logic            done;
    logic            err_seen;
    logic            overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_base;

    logic [AW+WW-1:0] exp_q[$];

    filter_slice_packer #(
        .SLICE_W   (SW),
        .ADDR_W    (AW),
        .NUM_WORDS (NW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .flush          (flush),
        .ast_sink_data  (ast_sink_data),
        .ast_sink_valid (ast_sink_valid),
        .ast_sink_error (ast_sink_error),
        .ram_addr       (ram_addr),
        .ram_data       (ram_data),
        .ram_wren       (ram_wren),
        .words_written  (words_written),
        .busy           (busy),
        .done           (done),
        .err_seen       (err_seen),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] w3(input logic [SW-1:0] s1,
                                         input logic [SW-1:0] s2,
                                         input logic [SW-1:0] s3);
        return {s3, s2, s1};
    endfunction

    task automatic push_exp(input logic [AW-1:0] a, input logic [WW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic beat(input logic v, input logic [SW-1:0] d, input logic [1:0] e,
                        input logic st, input logic fl);
        ast_sink_valid = v;
        ast_sink_data  = d;
        ast_sink_error = e;
        start          = st;
        flush          = fl;
        @(posedge clk);
        #1;
        ast_sink_valid = 1'b0;
        ast_sink_data  = '0;
        ast_sink_error = 2'b00;
        start          = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic sample(input logic [SW-1:0] d);
        beat(1'b1, d, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (rst && ram_wren) begin
            logic [AW+WW-1:0] e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", ram_addr, e[AW+WW-1:WW]);
                chk("wr_data", ram_data, e[WW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        ast_sink_valid = 1'b0;
        ast_sink_data = '0;
        ast_sink_error = 2'b00;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_words", words_written, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_seen, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        idle(1);

        // samples in IDLE are ignored
        wr_base = wr_cnt;
        for (int i = 0; i < 4; i++) sample(SW'(i + 9));
        idle(2);
        chk("idle_no_write", wr_cnt - wr_base, 0);
        chk("idle_busy", busy, 0);

        // ---------------- 6 back-to-back samples ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        chk("start_busy", busy, 1);
        wr_base = wr_cnt;
        push_exp(0, w3(1, 2, 3));
        push_exp(1, w3(4, 5, 6));
        for (int i = 1; i <= 6; i++) sample(SW'(i));
        idle(2);
        chk("b2b_writes", wr_cnt - wr_base, 2);
        chk("b2b_words", words_written, 2);
        chk("b2b_busy", busy, 1);
        chk("b2b_wren_low", ram_wren, 0);
        chk("b2b_hold_addr", ram_addr, 1);

        // ---------------- gapped extreme values ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        chk("restart_words", words_written, 0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'h7FFFFFFF, 31'h0, 31'h40000000));
        sample(31'h7FFFFFFF); idle(2);
        sample(31'h0);        idle(2);
        sample(31'h40000000); idle(2);
        chk("gap_writes", wr_cnt - wr_base, 1);
        chk("gap_slice3", ram_data[92:62], 31'h40000000);
        chk("gap_slice2", ram_data[61:31], 31'h0);
        chk("gap_slice1", ram_data[30:0], 31'h7FFFFFFF);

        // ---------------- flush partial word ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'hA, 31'hB, 31'h0));
        sample(31'hA);
        sample(31'hB);
        beat(1'b0, '0, 2'b00, 1'b0, 1'b1);
        chk("flush_state_busy", busy, 1);
        idle(2);
        chk("flush_writes", wr_cnt - wr_base, 1);
        chk("flush_done", done, 1);
        chk("flush_busy", busy, 0);
        chk("flush_words", words_written, 1);

        // flush after exactly 3 samples -> no extra write
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'hC, 31'hD, 31'hE));
        sample(31'hC); sample(31'hD); sample(31'hE);
        beat(1'b0, '0, 2'b00, 1'b0, 1'b1);
        idle(2);
        chk("flush3_writes", wr_cnt - wr_base, 1);
        chk("flush3_done", done, 1);
        chk("flush3_words", words_written, 1);

        // flush together with the word-completing sample
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'h11, 31'h22, 31'h33));
        sample(31'h11); sample(31'h22);
        beat(1'b1, 31'h33, 2'b00, 1'b0, 1'b1);
        chk("flushv_done", done, 1);
        idle(2);
        chk("flushv_writes", wr_cnt - wr_base, 1);

        // start and flush together: start wins
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        sample(31'h5);
        beat(1'b0, '0, 2'b00, 1'b1, 1'b1);
        chk("stfl_busy", busy, 1);
        chk("stfl_done", done, 0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'h6, 31'h7, 31'h8));
        sample(31'h6); sample(31'h7); sample(31'h8);
        idle(2);
        chk("stfl_writes", wr_cnt - wr_base, 1);

        // ---------------- frame end and overflow ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        wr_base = wr_cnt;
        for (int w = 0; w < NW; w++)
            push_exp(AW'(w), w3(SW'(3*w + 1), SW'(3*w + 2), SW'(3*w + 3)));
        for (int i = 1; i <= 12; i++) sample(SW'(i));
        chk("fe_done", done, 1);
        chk("fe_ovf_before", overflow, 0);
        sample(SW'(13));
        sample(SW'(14));
        idle(2);
        chk("fe_writes", wr_cnt - wr_base, NW);
        chk("fe_words", words_written, NW);
        chk("fe_ovf", overflow, 1);

        // ---------------- error code ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        chk("start_clr_ovf", overflow, 0);
        wr_base = wr_cnt;
`ifdef PACKER_ERR_DROP_EN
        push_exp(0, w3(31'h1, 31'h3, 31'h4));
`else
        push_exp(0, w3(31'h1, 31'h2, 31'h3));
        push_exp(1, w3(31'h4, 31'h0, 31'h0));
`endif
        sample(31'h1);
        beat(1'b1, 31'h2, 2'b01, 1'b0, 1'b0);
        chk("err_seen", err_seen, 1);
        sample(31'h3);
        sample(31'h4);
        beat(1'b0, '0, 2'b00, 1'b0, 1'b1);
        idle(2);
`ifdef PACKER_ERR_DROP_EN
        chk("err_writes", wr_cnt - wr_base, 1);
`else
        chk("err_writes", wr_cnt - wr_base, 2);
`endif
        chk("err_done", done, 1);

        // ---------------- async reset mid-word ----------------
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        sample(31'h55); sample(31'h66);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_addr", ram_addr, 0);
        chk("arst_data", ram_data, 0);
        chk("arst_words", words_written, 0);
        chk("arst_err", err_seen, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'h101, 31'h102, 31'h103));
        sample(31'h101); sample(31'h102); sample(31'h103);
        idle(2);
        chk("arst_writes", wr_cnt - wr_base, 1);

        // ---------------- start mid-frame ----------------
        sample(31'h201); sample(31'h202);
        beat(1'b0, '0, 2'b00, 1'b1, 1'b0);
        chk("rs_busy", busy, 1);
        chk("rs_addr", ram_addr, 0);
        chk("rs_words", words_written, 0);
        wr_base = wr_cnt;
        push_exp(0, w3(31'h301, 31'h302, 31'h303));
        sample(31'h301); sample(31'h302); sample(31'h303);
        idle(2);
        chk("rs_writes", wr_cnt - wr_base, 1);
        chk("rs_words_after", words_written, 1);

        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_slice_packer.md
Name: filter_slice_packer

Overview:
- Write side of the packed filter-output RAM.
- Accepts the band-pass filter's Avalon-ST source stream, one 31-bit sample per valid beat.
- Packs three consecutive samples into one 93-bit word and generates the address, data and write-enable for the output RAM's write port.
- Slice layout matches the downstream slice reader: slice1 at [30:0], slice2 at [61:31], slice3 at [92:62].

Parameters:
- SLICE_W, 31, width of one filter sample / RAM slice.
- ADDR_W, 11, output RAM address width.
- NUM_WORDS, 2048, packed words per frame; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms or re-arms a frame.
- flush  in  1  one-cycle pulse; writes any partial word and ends the frame.
- ast_sink_data  in  SLICE_W  filter output sample.
- ast_sink_valid  in  1  sample valid; no backpressure exists.
- ast_sink_error  in  2  filter error code; nonzero marks a bad sample.
- ram_addr  out  ADDR_W  write address.
- ram_data  out  3*SLICE_W  packed word.
- ram_wren  out  1  write strobe, one cycle per word.
- words_written  out  ADDR_W+1  words written this frame.
- busy  out  1  high in PACK and FLUSH.
- done  out  1  high in DONE.
- err_seen  out  1  sticky: a nonzero ast_sink_error was accepted.
- overflow  out  1  sticky: valid sample arrived while in DONE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; ram_addr=0, ram_data=0, ram_wren=0, words_written=0, busy=0, done=0, err_seen=0, overflow=0; slice counter and staging register cleared.
- States:
  - IDLE: samples ignored. start -> PACK.
  - PACK: each sample with ast_sink_valid=1 is accepted into staging slice slice_cnt (0,1,2) and slice_cnt advances. On the 3rd slice, the next edge registers ram_data = {s3,s2,s1}, ram_addr = words_written[ADDR_W-1:0], ram_wren=1 for exactly one cycle, words_written increments and slice_cnt wraps to 0.
  - FLUSH: one cycle. Writes the partial word, unused slices zero. Then -> DONE.
  - DONE: done=1, busy=0. Valid samples are dropped and set overflow. start -> PACK.
- Write latency: ram_wren rises on the edge after the cycle in which the 3rd slice is accepted; that is one clock after acceptance.
- Output register is separate from staging. A sample accepted in the same cycle ram_wren is high goes into slice1 of the next word. Full throughput is one sample per clock with no loss.
- Frame end:
  - When the write of word NUM_WORDS-1 is issued, the state moves PACK -> DONE on the same edge.
  - Samples arriving after that edge set overflow.
- flush handling:
  - flush in PACK with slice_cnt>0 -> FLUSH.
  - flush in PACK with slice_cnt=0 -> DONE directly, no write.
  - flush in IDLE or DONE: no effect.
- Simultaneous events:
  - flush and valid in the same cycle: the sample is packed first, then the flush is evaluated on the updated slice_cnt. If that sample completes a word, the full word is written and the state goes to DONE with no extra write.
  - start and flush in the same cycle: start wins.
- start in PACK or FLUSH: the frame restarts. Partial staging is discarded with no write; words_written, slice_cnt, err_seen and overflow are cleared; ram_addr returns to 0. The same clears apply to start from IDLE or DONE.
- ast_sink_error: a nonzero code on an accepted beat sets err_seen. The sample is still packed, unless the optional feature below is enabled.
- ram_data and ram_addr hold their last value when ram_wren=0.
- words_written saturates at NUM_WORDS.

Optional Feature:
- Macro: PACKER_ERR_DROP_EN.
- Defined: beats with ast_sink_valid=1 and ast_sink_error!=0 are not packed and do not advance slice_cnt; they still set err_seen.
- Undefined: errored beats are packed like good beats; only err_seen records them.

Test Plan:
- Reset, start, 6 back-to-back valid samples 1..6 -> ram_wren pulses at 2 cycles. Word0 ram_data = {3,2,1} at addr 0, word1 = {6,5,4} at addr 1. words_written=2, busy=1.
- Samples 0x7FFFFFFF, 0, 0x40000000 with valid gaps of 2 cycles -> one write, ram_data[92:62]=0x40000000, [61:31]=0, [30:0]=0x7FFFFFFF.
- NUM_WORDS=4, 14 samples -> 4 writes to addr 0..3, done=1 after the 4th write. The last 2 samples set overflow=1, and no 5th write occurs.
- 2 samples 0xA, 0xB then flush -> write at addr 0 with ram_data = {0,0xB,0xA}, then done=1. Flush after exactly 3 samples -> no extra write.
- Sample with ast_sink_error=2'b01 among 3 good samples -> err_seen=1. Without the macro, the first 3 beats form word0. With PACKER_ERR_DROP_EN, the errored beat is absent from word0.
- rst pulled low mid-word after 2 samples, or start pulsed mid-frame -> all outputs return to reset values (start: busy=1, addr 0). The next 3 samples produce word0 with no residue from the earlier partial word.
